// File: rtl/sp1_hmem_copier_pkg.sv
// Shared constants and state encoding for the heap block-move engine.
// Imported by the copier FSM and its address generator.
package sp1_hmem_copier_pkg;

  localparam int SP1_WORD_WIDTH = 32;
  localparam int SP1_HEAP_BYTES = 4096;
  localparam int SP1_HMCP_AW    = $clog2(SP1_HEAP_BYTES);
  localparam int SP1_HMCP_LW    = 10;

  localparam logic SP1_HMCP_MODE_COPY = 1'b0;
  localparam logic SP1_HMCP_MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    SP1_HMCP_ST_IDLE = 3'd0,
    SP1_HMCP_ST_CHK  = 3'd1,
    SP1_HMCP_ST_RD   = 3'd2,
    SP1_HMCP_ST_WR   = 3'd3,
    SP1_HMCP_ST_FILL = 3'd4,
    SP1_HMCP_ST_FIN  = 3'd5
  } sp1_hmcp_state_e;

endpackage

// File: rtl/sp1_hmem_copier_adrgen.sv
// Source/destination pair pointers and remaining-pair count for the copier.
// Loaded with the command, stepped by one 8-byte pair per write cycle.
module sp1_hmem_adrgen
  import sp1_hmem_copier_pkg::*;
#(
  parameter int AW = SP1_HMCP_AW,
  parameter int LW = SP1_HMCP_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] sp_init,
  input  logic [AW-1:0] dp_init,
  input  logic [LW-1:0] len_init,
  output logic [AW-1:0] sp,
  output logic [AW-1:0] dp,
  output logic          last
);

  logic [LW-1:0] rem;

  // The range check upstream guarantees neither pointer wraps past the heap end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      dp  <= '0;
      rem <= '0;
    end else if (load) begin
      sp  <= sp_init;
      dp  <= dp_init;
      rem <= len_init;
    end else if (step) begin
      sp  <= sp + AW'(8);
      dp  <= dp + AW'(8);
      rem <= rem - LW'(1);
    end
  end

  assign last = (rem == LW'(1));

endmodule

// File: rtl/sp1_hmem_copier.sv
// Heap block-move engine: copies or fills runs of 8-byte word pairs across the
// even/odd banks of the dual heap RAM, owning both RAM ports while busy.
module sp1_hmem_copier
  import sp1_hmem_copier_pkg::*;
#(
  parameter int DW = SP1_WORD_WIDTH,
  parameter int AW = SP1_HMCP_AW,
  parameter int LW = SP1_HMCP_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [DW-1:0] src,
  input  logic [DW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] fill_dt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cs_ev,
  output logic          cs_od,
  output logic          we_ev,
  output logic          we_od,
  output logic [DW-1:0] adrs_ev,
  output logic [DW-1:0] adrs_od,
  output logic [DW-1:0] wr_dt_ev,
  output logic [DW-1:0] wr_dt_od,
  input  logic [DW-1:0] rd_dt_ev,
  input  logic [DW-1:0] rd_dt_od
);

  localparam int CW = AW + LW + 4;
  localparam logic [CW-1:0] HEAP_END = CW'(SP1_HEAP_BYTES);

  sp1_hmcp_state_e state, state_nxt;

  logic          cmd_mode;
  logic [DW-1:0] cmd_src;
  logic [DW-1:0] cmd_dst;
  logic [DW-1:0] cmd_fill;
  logic [LW-1:0] cmd_len;
  logic          err_q;

  logic [AW-1:0] sp;
  logic [AW-1:0] dp;
  logic          last;
  logic          load;
  logic          step;

  logic [CW-1:0] src_end;
  logic [CW-1:0] dst_end;
  logic          dst_bad;
  logic          src_bad;
  logic          reject;

  assign load = (state == SP1_HMCP_ST_IDLE) && start;
  assign step = (state == SP1_HMCP_ST_WR) || (state == SP1_HMCP_ST_FILL);

  sp1_hmem_adrgen #(
    .AW(AW),
    .LW(LW)
  ) u_adrgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .sp_init  (src[AW-1:0]),
    .dp_init  (dst[AW-1:0]),
    .len_init (len),
    .sp       (sp),
    .dp       (dp),
    .last     (last)
  );

  // End addresses are computed wide enough that a long run cannot alias back into range.
  assign dst_end = CW'(cmd_dst[AW-1:0]) + (CW'(cmd_len) << 3);
  assign src_end = CW'(cmd_src[AW-1:0]) + (CW'(cmd_len) << 3);

  assign dst_bad = (cmd_dst[2:0] != 3'b000) || (cmd_dst[DW-1:AW] != '0) ||
                   (dst_end > HEAP_END);
  assign src_bad = (cmd_mode == SP1_HMCP_MODE_COPY) &&
                   ((cmd_src[2:0] != 3'b000) || (cmd_src[DW-1:AW] != '0) ||
                    (src_end > HEAP_END));
  assign reject  = dst_bad || src_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SP1_HMCP_ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command fields are frozen at the start edge; the verdict is held for the FIN pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_mode <= SP1_HMCP_MODE_COPY;
      cmd_src  <= '0;
      cmd_dst  <= '0;
      cmd_fill <= '0;
      cmd_len  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (load) begin
        cmd_mode <= mode;
        cmd_src  <= src;
        cmd_dst  <= dst;
        cmd_fill <= fill_dt;
        cmd_len  <= len;
      end
      if (state == SP1_HMCP_ST_CHK) begin
        err_q <= reject;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cs_ev     = 1'b0;
    cs_od     = 1'b0;
    we_ev     = 1'b0;
    we_od     = 1'b0;
    adrs_ev   = '0;
    adrs_od   = '0;
    wr_dt_ev  = '0;
    wr_dt_od  = '0;

    case (state)
      SP1_HMCP_ST_IDLE: begin
        if (start) begin
          state_nxt = SP1_HMCP_ST_CHK;
        end
      end

      SP1_HMCP_ST_CHK: begin
        busy = 1'b1;
        if (reject || (cmd_len == '0)) begin
          state_nxt = SP1_HMCP_ST_FIN;
        end else if (cmd_mode == SP1_HMCP_MODE_FILL) begin
          state_nxt = SP1_HMCP_ST_FILL;
        end else begin
          state_nxt = SP1_HMCP_ST_RD;
        end
      end

      SP1_HMCP_ST_RD: begin
        busy      = 1'b1;
        cs_ev     = 1'b1;
        cs_od     = 1'b1;
        adrs_ev   = DW'(sp);
        adrs_od   = DW'(sp + AW'(4));
        state_nxt = abort ? SP1_HMCP_ST_IDLE : SP1_HMCP_ST_WR;
      end

      // Read data returned from the RD cycle flows straight back out as write data.
      SP1_HMCP_ST_WR: begin
        busy     = 1'b1;
        cs_ev    = 1'b1;
        cs_od    = 1'b1;
        we_ev    = 1'b1;
        we_od    = 1'b1;
        adrs_ev  = DW'(dp);
        adrs_od  = DW'(dp + AW'(4));
        wr_dt_ev = rd_dt_ev;
        wr_dt_od = rd_dt_od;
        if (abort) begin
          state_nxt = SP1_HMCP_ST_IDLE;
        end else if (last) begin
          state_nxt = SP1_HMCP_ST_FIN;
        end else begin
          state_nxt = SP1_HMCP_ST_RD;
        end
      end

      SP1_HMCP_ST_FILL: begin
        busy     = 1'b1;
        cs_ev    = 1'b1;
        cs_od    = 1'b1;
        we_ev    = 1'b1;
        we_od    = 1'b1;
        adrs_ev  = DW'(dp);
        adrs_od  = DW'(dp + AW'(4));
        wr_dt_ev = cmd_fill;
        wr_dt_od = cmd_fill;
        if (abort) begin
          state_nxt = SP1_HMCP_ST_IDLE;
        end else if (last) begin
          state_nxt = SP1_HMCP_ST_FIN;
        end
      end

      SP1_HMCP_ST_FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        err       = err_q;
        state_nxt = SP1_HMCP_ST_IDLE;
      end

      default: begin
        state_nxt = SP1_HMCP_ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sp1_hmem_copier.sv
// Self-checking bench for sp1_hmem_copier: directed and random copy/fill commands
// against a word-pair array model of the heap, with a behavioural dual-bank RAM.
module tb_sp1_hmem_copier;
  import sp1_hmem_copier_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [9:0]  len = '0;
  logic [31:0] fill_dt = '0;
  logic        busy, done, err;
  logic        cs_ev, cs_od, we_ev, we_od;
  logic [31:0] adrs_ev, adrs_od, wr_dt_ev, wr_dt_od;
  logic [31:0] rd_dt_ev = '0;
  logic [31:0] rd_dt_od = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sp1_hmem_copier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill_dt  (fill_dt),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cs_ev    (cs_ev),
    .cs_od    (cs_od),
    .we_ev    (we_ev),
    .we_od    (we_od),
    .adrs_ev  (adrs_ev),
    .adrs_od  (adrs_od),
    .wr_dt_ev (wr_dt_ev),
    .wr_dt_od (wr_dt_od),
    .rd_dt_ev (rd_dt_ev),
    .rd_dt_od (rd_dt_od)
  );

  // Behavioural dual-bank RAM indexed by pair number, plus a bench-side preload port.
  logic [31:0] mem_ev [512];
  logic [31:0] mem_od [512];
  logic        tb_we = 1'b0;
  logic [8:0]  tb_idx = '0;
  logic [31:0] tb_ev = '0;
  logic [31:0] tb_od = '0;
  int          bad_adr = 0;

  always @(posedge clk) begin
    if (cs_ev || cs_od) begin
      if (!(cs_ev && cs_od && (we_ev == we_od) && (adrs_ev[2:0] == 3'b000) &&
            (adrs_od == adrs_ev + 32'd4) && (adrs_ev[31:12] == '0)))
        bad_adr <= bad_adr + 1;
      if (we_ev) mem_ev[adrs_ev[11:3]] <= wr_dt_ev;
      else       rd_dt_ev <= mem_ev[adrs_ev[11:3]];
      if (we_od) mem_od[adrs_od[11:3]] <= wr_dt_od;
      else       rd_dt_od <= mem_od[adrs_od[11:3]];
    end else if (tb_we) begin
      mem_ev[tb_idx] <= tb_ev;
      mem_od[tb_idx] <= tb_od;
    end
  end

  // Reference heap image, one entry per 8-byte pair per bank.
  logic [31:0] ref_ev [512];
  logic [31:0] ref_od [512];

  int   res_done_cyc;
  logic res_err;
  int   res_cs;
  int   res_wr;
  logic res_busy1;
  logic res_busy_after;
  logic res_done_after;
  logic res_quiet;
  logic res_reset_outs;

  function automatic logic any_ram();
    return cs_ev | cs_od | we_ev | we_od | (|adrs_ev) | (|adrs_od) |
           (|wr_dt_ev) | (|wr_dt_od);
  endfunction

  function automatic logic any_out();
    return busy | done | err | any_ram();
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_reject(input logic m, input logic [31:0] s,
                                    input logic [31:0] d, input logic [9:0] l);
    longint unsigned span, sa, da;
    bit bad;
    span = 64'(l) * 8;
    sa   = 64'(s);
    da   = 64'(d);
    bad  = (da % 8 != 0) || (da >= 4096) || (da + span > 4096);
    if (m == SP1_HMCP_MODE_COPY)
      bad = bad || (sa % 8 != 0) || (sa >= 4096) || (sa + span > 4096);
    return bad;
  endfunction

  task automatic model_apply(input logic m, input logic [31:0] s, input logic [31:0] d,
                             input logic [31:0] f, input int npairs);
    int si, di;
    si = int'(s[11:0]) / 8;
    di = int'(d[11:0]) / 8;
    for (int i = 0; i < npairs; i++) begin
      if (m == SP1_HMCP_MODE_FILL) begin
        ref_ev[di + i] = f;
        ref_od[di + i] = f;
      end else begin
        ref_ev[di + i] = ref_ev[si + i];
        ref_od[di + i] = ref_od[si + i];
      end
    end
  endtask

  task automatic check_memory(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 0; i < 512; i++) begin
      if (mem_ev[i] !== ref_ev[i]) nbad++;
      if (mem_od[i] !== ref_od[i]) nbad++;
    end
    check_output(tag, 64'(nbad), 64'd0);
  endtask

  task automatic preload(input int idx, input logic [31:0] ev, input logic [31:0] od);
    @(negedge clk);
    tb_idx = 9'(idx);
    tb_ev  = ev;
    tb_od  = od;
    tb_we  = 1'b1;
    ref_ev[idx] = ev;
    ref_od[idx] = od;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issues one command and observes it cycle by cycle; cycle 1 is the one after the start edge.
  task automatic apply_stimulus(input logic m, input logic [31:0] s, input logic [31:0] d,
                                input logic [9:0] l, input logic [31:0] f,
                                input int abort_cyc, input int reset_cyc);
    int cyc;
    bit fin_seen;
    res_done_cyc   = -1;
    res_err        = 1'b0;
    res_cs         = 0;
    res_wr         = 0;
    res_busy_after = 1'b1;
    res_done_after = 1'b1;
    res_quiet      = 1'b1;
    res_reset_outs = 1'b1;
    fin_seen       = 1'b0;
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill_dt = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 1'($urandom); src = $urandom; dst = $urandom;
    len = 10'($urandom); fill_dt = $urandom;
    res_busy1 = busy;
    cyc = 1;
    while (cyc < 400) begin
      if (cs_ev) res_cs++;
      if (cs_ev && we_ev) res_wr++;
      if (done) begin
        res_done_cyc = cyc;
        res_err      = err;
        fin_seen     = 1'b1;
        start = 1'b1; mode = SP1_HMCP_MODE_FILL; dst = '0; len = 10'd1;
      end
      if (cyc == abort_cyc) abort = 1'b1;
      if (cyc == reset_cyc) begin
        rst_n = 1'b0;
        #1;
        res_reset_outs = any_out();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
      abort = 1'b0;
      if (fin_seen || (abort_cyc > 0 && cyc == abort_cyc + 1)) begin
        start          = 1'b0;
        res_busy_after = busy;
        res_done_after = done;
        res_quiet      = any_ram();
        break;
      end
    end
    start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_dt = '0;
  endtask

  task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [9:0] l, input logic [31:0] f);
    bit rej;
    int exp_done, exp_cs;
    rej = exp_reject(m, s, d, l);
    apply_stimulus(m, s, d, l, f, 0, 0);
    if (rej || l == 0) begin
      exp_done = 2;
      exp_cs   = 0;
    end else begin
      exp_done = (m == SP1_HMCP_MODE_FILL) ? 2 + int'(l) : 2 + 2 * int'(l);
      exp_cs   = (m == SP1_HMCP_MODE_FILL) ? int'(l) : 2 * int'(l);
      model_apply(m, s, d, f, int'(l));
    end
    check_output("busy_rise",    64'(res_busy1), 64'd1);
    check_output("done_cycle",   64'(res_done_cyc), 64'(exp_done));
    check_output("err_flag",     64'(res_err), 64'(rej));
    check_output("cs_cycles",    64'(res_cs), 64'(exp_cs));
    check_output("busy_after",   64'(res_busy_after), 64'd0);
    check_output("done_pulse",   64'(res_done_after), 64'd0);
    check_output("idle_outputs", 64'(res_quiet), 64'd0);
    check_output("adr_pairing",  64'(bad_adr), 64'd0);
    check_memory("heap_image");
  endtask

  initial begin
    logic        rm;
    logic [31:0] rs, rd;
    logic [9:0]  rl;

    $display("[TB] start");
    rst_n = 1'b0;
    @(negedge clk);
    check_output("reset_state", 64'(any_out()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 512; i++) preload(i, $urandom, $urandom);
    preload(32'h14, 32'ha0a0a0a0, 32'ha4a4a4a4);
    preload(32'h15, 32'ha8a8a8a8, 32'hacacacac);
    preload(32'h16, 32'hb0b0b0b0, 32'hb4b4b4b4);
    preload(32'h17, 32'hb8b8b8b8, 32'hb9b9b9b9);

    $display("[TB] fill 0x100 x4");
    run_cmd(SP1_HMCP_MODE_FILL, 32'h0, 32'h100, 10'd4, 32'ha5a5a5a5);
    check_output("fill_ev_118", 64'(mem_ev[9'h23]), 64'ha5a5a5a5);
    check_output("fill_od_11c", 64'(mem_od[9'h23]), 64'ha5a5a5a5);

    $display("[TB] copy 0x0a0 -> 0x200 x4");
    run_cmd(SP1_HMCP_MODE_COPY, 32'h0a0, 32'h200, 10'd4, 32'h0);
    check_output("copy_200", 64'(mem_ev[9'h40]), 64'ha0a0a0a0);
    check_output("copy_21c", 64'(mem_od[9'h43]), 64'hb9b9b9b9);

    $display("[TB] heap-end boundary");
    run_cmd(SP1_HMCP_MODE_COPY, 32'h010, 32'hff8, 10'd1, 32'h0);
    run_cmd(SP1_HMCP_MODE_COPY, 32'h010, 32'hff8, 10'd2, 32'h0);
    run_cmd(SP1_HMCP_MODE_FILL, 32'h0, 32'h104, 10'd1, 32'h12345678);
    run_cmd(SP1_HMCP_MODE_FILL, 32'h0, 32'h180, 10'd0, 32'h12345678);
    run_cmd(SP1_HMCP_MODE_COPY, 32'h1_0000, 32'h180, 10'd1, 32'h0);
    run_cmd(SP1_HMCP_MODE_FILL, 32'h0, 32'h1000, 10'd0, 32'h0);
    run_cmd(SP1_HMCP_MODE_COPY, 32'h400, 32'h408, 10'd4, 32'h0);

    $display("[TB] abort in third fill cycle");
    apply_stimulus(SP1_HMCP_MODE_FILL, 32'h0, 32'h300, 10'd8, 32'h5a5a0f0f, 4, 0);
    model_apply(SP1_HMCP_MODE_FILL, 32'h0, 32'h300, 32'h5a5a0f0f, 3);
    check_output("abort_writes", 64'(res_wr), 64'd3);
    check_output("abort_nodone", 64'(res_done_cyc), 64'(-1));
    check_output("abort_busy",   64'(res_busy_after), 64'd0);
    check_memory("abort_image");

    $display("[TB] reset mid-copy");
    apply_stimulus(SP1_HMCP_MODE_COPY, 32'h500, 32'h600, 10'd6, 32'h0, 0, 6);
    model_apply(SP1_HMCP_MODE_COPY, 32'h500, 32'h600, 32'h0, 2);
    check_output("reset_outputs", 64'(res_reset_outs), 64'd0);
    check_memory("reset_image");
    run_cmd(SP1_HMCP_MODE_COPY, 32'h500, 32'h600, 10'd6, 32'h0);

    $display("[TB] random commands");
    for (int n = 0; n < 24; n++) begin
      rm = 1'($urandom_range(0, 1));
      rl = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 12));
      rd = {20'h0, 9'($urandom_range(0, 511)), 3'b000};
      rs = {20'h0, 9'($urandom_range(0, 511)), 3'b000};
      if ($urandom_range(0, 7) == 0) rd[2:0] = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) rd[20] = 1'b1;
      if (rm == SP1_HMCP_MODE_COPY && $urandom_range(0, 7) == 0)
        rs[2:0] = 3'($urandom_range(1, 7));
      run_cmd(rm, rs, rd, rl, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
